// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the Execute stage and the multiply/divide unit.
interface mult_div_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        hi_write;
  logic        lo_write;
  logic [31:0] hi_data;
  logic [31:0] lo_data;

  modport master (
    output start, op, a, b, flush,
    input  busy, hi_write, lo_write, hi_data, lo_data
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, hi_write, lo_write, hi_data, lo_data
  );
endinterface

// File: rtl/mult_div_unit.sv
// Sequential MULT/MULTU/DIV/DIVU engine producing the HI/LO write port.
// Multiply takes MUL_CYCLES+1 cycles to the write pulse, divide takes 33; flush aborts without writing.
module mult_div_unit #(
  parameter int unsigned MUL_CYCLES = 1
) (
  input  logic            clk,
  input  logic            reset,
  mult_div_unit_if.slave  bus
);
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  localparam logic [4:0] MUL_LAST = 5'(MUL_CYCLES - 1);

  state_t     state_q;
  logic [4:0] cnt_q;
  logic       sgn_q;
  word_t      a_q, b_q;
  word_t      quo_q, rem_q, dvs_q;
  word_t      res_hi_q, res_lo_q;
  word_t      out_hi_q, out_lo_q;

  logic [63:0] ext_a, ext_b, prod;
  logic [32:0] rem_sh;
  word_t       rem_step, quo_step, q_fix, r_fix;
  word_t       a_mag, b_mag;
  logic        wr;

  // Sign-extending only for MULT lets one 64x64 low-half product serve both ops.
  assign ext_a = {{32{sgn_q & a_q[31]}}, a_q};
  assign ext_b = {{32{sgn_q & b_q[31]}}, b_q};
  assign prod  = ext_a * ext_b;

  assign a_mag = (~bus.op[0] & bus.a[31]) ? (~bus.a + 32'd1) : bus.a;
  assign b_mag = (~bus.op[0] & bus.b[31]) ? (~bus.b + 32'd1) : bus.b;

  // One restoring step: quo_q shifts the dividend out while collecting quotient bits.
  always_comb begin
    rem_sh   = {rem_q, quo_q[31]};
    rem_step = rem_sh[31:0];
    quo_step = {quo_q[30:0], 1'b0};
    if (rem_sh >= {1'b0, dvs_q}) begin
      rem_step = 32'(rem_sh - {1'b0, dvs_q});
      quo_step = {quo_q[30:0], 1'b1};
    end
    q_fix = (sgn_q & (a_q[31] ^ b_q[31])) ? (~quo_step + 32'd1) : quo_step;
    r_fix = (sgn_q & a_q[31]) ? (~rem_step + 32'd1) : rem_step;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sgn_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      out_hi_q <= '0;
      out_lo_q <= '0;
    end else if (bus.flush) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            sgn_q   <= ~bus.op[0];
            a_q     <= bus.a;
            b_q     <= bus.b;
            quo_q   <= a_mag;
            rem_q   <= '0;
            dvs_q   <= b_mag;
            cnt_q   <= '0;
            state_q <= bus.op[1] ? DIV : MUL;
          end
        end
        MUL: begin
          if (cnt_q == MUL_LAST) begin
            res_hi_q <= prod[63:32];
            res_lo_q <= prod[31:0];
            state_q  <= DONE;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        DIV: begin
          quo_q <= quo_step;
          rem_q <= rem_step;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            if (b_q == '0) begin
              res_hi_q <= a_q;
              res_lo_q <= 32'hFFFF_FFFF;
            end else begin
              res_hi_q <= r_fix;
              res_lo_q <= q_fix;
            end
            state_q <= DONE;
          end
        end
        DONE: begin
          out_hi_q <= res_hi_q;
          out_lo_q <= res_lo_q;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The new result is shown only alongside an unflushed write pulse, so a flushed DONE leaves old data.
  assign wr           = (state_q == DONE) & ~bus.flush;
  assign bus.busy     = (state_q != IDLE);
  assign bus.hi_write = wr;
  assign bus.lo_write = wr;
  assign bus.hi_data  = wr ? res_hi_q : out_hi_q;
  assign bus.lo_data  = wr ? res_lo_q : out_lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit with a scoreboard of expected HI/LO write pulses.
module tb_mult_div_unit;
  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q0[$];
  exp_t q1[$];

  mult_div_unit_if bus0();
  mult_div_unit_if bus1();

  mult_div_unit #(.MUL_CYCLES(1)) u_dut0 (.clk(clk), .reset(reset), .bus(bus0));
  mult_div_unit #(.MUL_CYCLES(3)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic on_pulse(input string tag, input logic hw, input logic lw,
                          input logic [31:0] hd, input logic [31:0] ld, input exp_t e);
    chk({tag, "_lo_write"}, 64'(lw), 64'(hw));
    chk({tag, "_hi"}, 64'(hd), 64'(e.hi));
    chk({tag, "_lo"}, 64'(ld), 64'(e.lo));
    chk({tag, "_cycle"}, 64'(cyc), 64'(e.cyc));
  endtask

  // Scoreboard monitors: every write pulse must match the oldest expectation.
  always @(negedge clk) begin
    #1;
    if (bus0.hi_write) begin
      if (q0.size() == 0) chk("dut0_unexpected_pulse", 64'd1, 64'd0);
      else on_pulse("dut0", bus0.hi_write, bus0.lo_write, bus0.hi_data, bus0.lo_data, q0.pop_front());
    end
    if (bus1.hi_write) begin
      if (q1.size() == 0) chk("dut1_unexpected_pulse", 64'd1, 64'd0);
      else on_pulse("dut1", bus1.hi_write, bus1.lo_write, bus1.hi_data, bus1.lo_data, q1.pop_front());
    end
  end

  task automatic goto(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic issue0(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, output int k);
    @(negedge clk);
    bus0.start = 1'b1;
    bus0.op = op;
    bus0.a = a;
    bus0.b = b;
    k = cyc;
    @(negedge clk);
    bus0.start = 1'b0;
  endtask

  initial begin
    int k;
    bus0.start = 1'b0; bus0.flush = 1'b0; bus0.op = 2'b00; bus0.a = '0; bus0.b = '0;
    bus1.start = 1'b0; bus1.flush = 1'b0; bus1.op = 2'b00; bus1.a = '0; bus1.b = '0;

    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(bus0.busy), 64'd0);
    chk("rst_hi_write", 64'(bus0.hi_write), 64'd0);
    chk("rst_lo_write", 64'(bus0.lo_write), 64'd0);
    chk("rst_hi_data", 64'(bus0.hi_data), 64'd0);
    chk("rst_lo_data", 64'(bus0.lo_data), 64'd0);
    reset = 1'b0;

    // MULT 7 * -3
    issue0(2'b00, 32'd7, 32'hFFFF_FFFD, k);
    q0.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFEB, k + 2});
    chk("mult_busy_c1", 64'(bus0.busy), 64'd1);
    @(negedge clk);
    chk("mult_busy_c2", 64'(bus0.busy), 64'd1);
    @(negedge clk);
    chk("mult_busy_c3", 64'(bus0.busy), 64'd0);
    chk("mult_hold_lo", 64'(bus0.lo_data), 64'hFFFF_FFEB);

    // MULTU max*max on the MUL_CYCLES=3 instance
    @(negedge clk);
    bus1.start = 1'b1; bus1.op = 2'b01; bus1.a = 32'hFFFF_FFFF; bus1.b = 32'hFFFF_FFFF;
    k = cyc;
    q1.push_back('{32'hFFFF_FFFE, 32'h0000_0001, k + 4});
    @(negedge clk);
    bus1.start = 1'b0;
    goto(k + 5);
    chk("multu3_idle", 64'(bus1.busy), 64'd0);

    // DIVU 100/7 with an ignored start at cycle 5
    issue0(2'b11, 32'd100, 32'd7, k);
    q0.push_back('{32'd2, 32'd14, k + 33});
    goto(k + 5);
    bus0.start = 1'b1; bus0.op = 2'b00; bus0.a = 32'd3; bus0.b = 32'd3;
    @(negedge clk);
    bus0.start = 1'b0;
    goto(k + 33);
    chk("divu_busy_done", 64'(bus0.busy), 64'd1);
    goto(k + 34);
    chk("divu_idle", 64'(bus0.busy), 64'd0);

    issue0(2'b10, 32'hFFFF_FFF9, 32'd2, k);
    q0.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFD, k + 33});
    goto(k + 34);

    issue0(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, k);
    q0.push_back('{32'h0000_0000, 32'h8000_0000, k + 33});
    goto(k + 34);

    issue0(2'b11, 32'd5, 32'd0, k);
    q0.push_back('{32'd5, 32'hFFFF_FFFF, k + 33});
    goto(k + 34);

    // Flush at cycle 10 of a DIV, then start again in the very next cycle
    issue0(2'b10, 32'd1000, 32'd3, k);
    goto(k + 10);
    bus0.flush = 1'b1;
    @(negedge clk);
    bus0.flush = 1'b0;
    chk("flush_busy", 64'(bus0.busy), 64'd0);
    chk("flush_hi_hold", 64'(bus0.hi_data), 64'd5);
    chk("flush_lo_hold", 64'(bus0.lo_data), 64'hFFFF_FFFF);
    bus0.start = 1'b1; bus0.op = 2'b00; bus0.a = 32'd2; bus0.b = 32'd3;
    k = cyc;
    q0.push_back('{32'd0, 32'd6, k + 2});
    @(negedge clk);
    bus0.start = 1'b0;
    chk("restart_busy", 64'(bus0.busy), 64'd1);
    goto(k + 3);

    // Flush together with start in IDLE drops the request
    bus0.start = 1'b1; bus0.flush = 1'b1; bus0.op = 2'b00; bus0.a = 32'd9; bus0.b = 32'd9;
    @(negedge clk);
    bus0.start = 1'b0; bus0.flush = 1'b0;
    chk("flush_start_busy", 64'(bus0.busy), 64'd0);
    repeat (3) @(negedge clk);

    // Flush in DONE suppresses the pulse and keeps the old data
    issue0(2'b00, 32'd4, 32'd5, k);
    @(negedge clk);
    bus0.flush = 1'b1;
    #1;
    chk("flush_done_hi_write", 64'(bus0.hi_write), 64'd0);
    chk("flush_done_lo_write", 64'(bus0.lo_write), 64'd0);
    chk("flush_done_lo_data", 64'(bus0.lo_data), 64'd6);
    @(negedge clk);
    bus0.flush = 1'b0;
    chk("flush_done_busy", 64'(bus0.busy), 64'd0);
    chk("flush_done_lo_after", 64'(bus0.lo_data), 64'd6);

    // Reset at cycle 20 of a DIV
    issue0(2'b10, 32'd77, 32'd5, k);
    goto(k + 20);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", 64'(bus0.busy), 64'd0);
    chk("mid_rst_hi_write", 64'(bus0.hi_write), 64'd0);
    chk("mid_rst_hi_data", 64'(bus0.hi_data), 64'd0);
    chk("mid_rst_lo_data", 64'(bus0.lo_data), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);

    chk("dut0_pending", 64'(q0.size()), 64'd0);
    chk("dut1_pending", 64'(q1.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multi-cycle multiply/divide engine in the Execute stage, and the producer for the HI/LO register pair. It accepts one MULT/MULTU/DIV/DIVU request at a time and computes the 64-bit result sequentially. It then emits a single-cycle write pulse with the high and low words on the HI/LO register write port. `busy` stalls the pipeline, and `flush` aborts an in-flight operation with no write.

## Interface
- `MUL_CYCLES`, default 1: number of cycles spent in state MUL; legal range 1..4. The product is registered at the end of the last MUL cycle.
- One clock; reset is asynchronous and active-high.
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-high; clears all state and outputs.
- `start`  in  1: request strobe; sampled only while `busy`=0.
- `op`  in  2: operation. 2'b00 MULT, 2'b01 MULTU, 2'b10 DIV, 2'b11 DIVU.
- `a`  in  32 (word_t): multiplicand / dividend; captured when `start` is accepted.
- `b`  in  32 (word_t): multiplier / divisor; captured when `start` is accepted.
- `flush`  in  1: synchronous abort.
- `busy`  out  1: high whenever the state is not IDLE.
- `hi_write`, `lo_write`  out  1 each: result write strobes to the HI/LO registers; always equal to each other.
- `hi_data`, `lo_data`  out  32 (word_t): result words. These hold their value between operations.

## Operation
- FSM states:
  - IDLE: `start`=1 and `flush`=0 captures `a`, `b`, `op`. The next state is MUL for op[1]=0, or DIV for op[1]=1.
  - MUL: stays MUL_CYCLES cycles.
    - MULT computes the 64-bit signed product of `a`×`b`; MULTU computes the unsigned product.
    - The result register receives {hi,lo} = product[63:32], product[31:0].
    - Next state is DONE.
  - DIV: restoring radix-2 division on operand magnitudes, exactly 32 iterations tracked by a 5-bit counter (0..31).
    - After iteration 31, apply the sign fix-up and load the result register. Next state is DONE.
    - The quotient is negated when DIV operand signs differ.
    - The remainder takes the sign of the dividend (DIV only).
    - lo = quotient, hi = remainder.
  - DONE: `hi_write`=`lo_write`=1 for exactly one cycle. Next state is IDLE.
- Divide by zero (b==0, DIV or DIVU):
  - Result is lo=32'hFFFF_FFFF, hi=`a`.
  - Latency is the same as a normal divide.
- Signed overflow, DIV 32'h8000_0000 / 32'hFFFF_FFFF: lo=32'h8000_0000, hi=0.
- `start` while `busy`=1 is ignored; there is no queueing.
- `flush`=1 in any state:
  - Next state is IDLE.
  - `hi_write`/`lo_write` are forced to 0 combinationally in that cycle, including in DONE.
  - `hi_data`/`lo_data` keep their prior value.
- `flush` and `start` together in IDLE: `flush` wins and the request is dropped.
- Reset mid-operation: immediately returns to IDLE.

## Timing
- Reset values: state IDLE; `busy`=0; `hi_write`=`lo_write`=0; `hi_data`=`lo_data`=0; counter 0.
- Cycle 0 is the cycle in which `start` is sampled high in IDLE. `busy` rises in cycle 1.
- Multiply:
  - MUL occupies cycles 1..MUL_CYCLES.
  - The write pulse is in cycle MUL_CYCLES+1 (cycle 2 at the default).
  - IDLE in cycle MUL_CYCLES+2.
- Divide:
  - DIV occupies cycles 1..32.
  - The write pulse is in cycle 33.
  - IDLE in cycle 34.
- `busy` is high during DONE. The earliest back-to-back `start` is accepted in the first IDLE cycle.
- `hi_data`/`lo_data` are valid from the write-pulse cycle onward and remain stable until the next write pulse.
- After a flush in cycle n: `busy`=0 in cycle n+1, and a new `start` is accepted in cycle n+1.

## Test plan
- **Signed multiply:** MULT a=7, b=32'hFFFF_FFFD (-3) -> single pulse at cycle 2 with hi=32'hFFFF_FFFF, lo=32'hFFFF_FFEB; `busy` high for cycles 1-2.
- **Unsigned multiply:** MULTU a=b=32'hFFFF_FFFF -> hi=32'hFFFF_FFFE, lo=32'h0000_0001; with MUL_CYCLES=3 the pulse moves to cycle 4.
- **Unsigned divide:** DIVU a=100, b=7 -> pulse at cycle 33 with lo=14, hi=2.
- **Signed divide:** DIV a=-7 (32'hFFFF_FFF9), b=2 -> lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF.
- **Corner-case divides:**
  - DIV 32'h8000_0000 / -1 -> lo=32'h8000_0000, hi=0.
  - DIVU 5/0 -> lo=32'hFFFF_FFFF, hi=5, pulse at cycle 33.
- **Flush, ignored start and reset:**
  - Flush at cycle 10 of a DIV -> no write pulse; `busy`=0 at cycle 11; data outputs unchanged.
  - `start` pulsed at cycle 5 of a DIV -> ignored, exactly one pulse.
  - Asserting `reset` at cycle 20 -> all outputs read 0 immediately.
